// File: rtl/cic_decim_shifted.sv
// Four-stage CIC decimator with rate-dependent output normalisation.
// Integrators run at the input sample rate. Combs run once per R input
// samples. The comb result is arithmetically shifted by ceil(4*log2(R)),
// which keeps the DC gain at or below one.
module cic_decim_shifted #(
    parameter int bw               = 16,
    parameter int N                = 4,
    parameter int log2_of_max_rate = 7,
    parameter int maxbitgain       = N * log2_of_max_rate
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic [7:0]    rate,
    input  logic          strobe_in,
    input  logic [bw-1:0] signal_in,
    output logic          strobe_out,
    output logic [bw-1:0] signal_out
);

    localparam int W  = bw + maxbitgain;
    localparam int SW = $clog2(maxbitgain + 1);
    localparam logic [7:0] RATE_MAX = 8'((1 << log2_of_max_rate) - 1);

    // Smallest s with 2^s >= R^4, which is ceil(4*log2(R)).
    // Any R above the supported maximum uses the largest shift.
    function automatic logic [SW-1:0] rateToShift(input logic [7:0] r);
        logic [8:0]    rr;
        logic [17:0]   r2;
        logic [35:0]   r4;
        logic [SW-1:0] s;
        rr = {1'b0, r} + 9'd1;
        r2 = {9'd0, rr} * {9'd0, rr};
        r4 = {18'd0, r2} * {18'd0, r2};
        s  = SW'(maxbitgain);
        for (int k = maxbitgain; k >= 0; k--) begin
            if ((36'd1 << k) >= r4) begin
                s = k[SW-1:0];
            end
        end
        if (r > RATE_MAX) begin
            s = SW'(maxbitgain);
        end
        return s;
    endfunction

    logic [W-1:0]  integ0_q, integ1_q, integ2_q, integ3_q;
    logic [W-1:0]  delay0_q, delay1_q, delay2_q, delay3_q;
    logic [7:0]    sampleCnt_q;
    logic          primed_q;
    logic          strobeOut_q;
    logic [bw-1:0] signalOut_q;

    logic [W-1:0]  xExt;
    logic [7:0]    effCnt;
    logic [7:0]    sampleCnt_d;
    logic          decStrb;
    logic [W-1:0]  comb0, comb1, comb2, comb3;
    logic [SW-1:0] shiftAmt;
    logic [bw-1:0] signalOut_d;

    // Counter start and wrap detection, comb chain and normalising shift.
    // Until the first accepted sample, the counter behaves as if it had
    // just been loaded with rate. This avoids an asynchronous load.
    always_comb begin
        xExt        = {{maxbitgain{signal_in[bw-1]}}, signal_in};
        effCnt      = primed_q ? sampleCnt_q : rate;
        sampleCnt_d = (effCnt == 8'd0) ? rate : effCnt - 8'd1;
        decStrb     = enable & strobe_in & (effCnt == 8'd0);
        comb0       = integ3_q - delay0_q;
        comb1       = comb0 - delay1_q;
        comb2       = comb1 - delay2_q;
        comb3       = comb2 - delay3_q;
        shiftAmt    = rateToShift(rate);
        signalOut_d = comb3[shiftAmt +: bw];
    end

    // Integrators, decimation counter, comb delays and output register.
    // Integrator sums wrap modulo 2^W. The combs cancel the wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            integ0_q    <= '0;
            integ1_q    <= '0;
            integ2_q    <= '0;
            integ3_q    <= '0;
            delay0_q    <= '0;
            delay1_q    <= '0;
            delay2_q    <= '0;
            delay3_q    <= '0;
            sampleCnt_q <= '0;
            primed_q    <= 1'b0;
            strobeOut_q <= 1'b0;
            signalOut_q <= '0;
        end else if (!enable) begin
            integ0_q    <= '0;
            integ1_q    <= '0;
            integ2_q    <= '0;
            integ3_q    <= '0;
            delay0_q    <= '0;
            delay1_q    <= '0;
            delay2_q    <= '0;
            delay3_q    <= '0;
            sampleCnt_q <= '0;
            primed_q    <= 1'b0;
            strobeOut_q <= 1'b0;
            signalOut_q <= '0;
        end else begin
            if (strobe_in) begin
                integ0_q    <= integ0_q + xExt;
                integ1_q    <= integ1_q + integ0_q;
                integ2_q    <= integ2_q + integ1_q;
                integ3_q    <= integ3_q + integ2_q;
                sampleCnt_q <= sampleCnt_d;
                primed_q    <= 1'b1;
            end
            if (decStrb) begin
                delay0_q    <= integ3_q;
                delay1_q    <= comb0;
                delay2_q    <= comb1;
                delay3_q    <= comb2;
                signalOut_q <= signalOut_d;
            end
            strobeOut_q <= decStrb;
        end
    end

    assign strobe_out = strobeOut_q;
    assign signal_out = signalOut_q;

endmodule
